pes_alu_sequencer: RTL and testbench

//  Command-side driver for the 8-bit registered ALU (ports A, B, op in; R out, R registered on posedge clk).

---
 rtl/pes_alu_pkg.sv | 32 +++
 rtl/pes_alu_cmd_fifo.sv | 55 +++++
 rtl/pes_alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_pes_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pes_alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - ALU opcode constants
//   - sequencer FSM state encoding
//   - command FIFO depth and the tag-less command payload struct
package pes_alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_NAND = 3'd3;
  localparam logic [2:0] ALU_NOR  = 3'd4;
  localparam logic [2:0] ALU_AND  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam int FIFO_DEPTH = 4;

  // Operand/opcode part of a command. The tag width is a module
  // parameter, so it is carried alongside this struct.
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/pes_alu_cmd_fifo.sv
// Command FIFO, FIFO_DEPTH entries of W bits, synchronous active-high reset.
// Ports:
//   clk, rst        clock / sync reset
//   push, wdata     write request (ignored when full)
//   pop,  rdata     read request (ignored when empty); rdata shows the head
//   full, empty     status
//   level           number of stored entries, 0..FIFO_DEPTH
// No bypass: an entry written on an edge is visible at the head afterwards.
module pes_alu_cmd_fifo
  import pes_alu_pkg::*;
#(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [2:0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == 3'(FIFO_DEPTH));
  assign empty   = (level == 3'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: reads are gated by level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pes_alu_sequencer.sv
// Command-side driver for an 8-bit registered ALU.
// Accepts (op, a, b, tag) commands over valid/ready into a 4-deep FIFO,
// issues one at a time to the ALU, captures R after ALU_LAT cycles and
// returns (R, tag) over valid/ready, strictly in command order.
// Ports:
//   clk, rst                         clock / sync active-high reset
//   cmd_valid/ready/op/a/b/tag       command input handshake
//   alu_a, alu_b, alu_op, alu_r      ALU connection
//   res_valid/ready/data/tag         result output handshake
//   fifo_level                       queued commands 0..4
//   busy                             FSM in EXEC or RESP
//   op_count                         completed result handoffs, wraps
module pes_alu_sequencer
  import pes_alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [2:0]       fifo_level,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int FW = TAG_W + $bits(alu_cmd_t);
  // Wide enough to hold ALU_LAT with headroom for the compare.
  localparam int LW = $clog2(ALU_LAT + 2);

  seq_state_e       state, state_nxt;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             pop, cap, done;
  alu_cmd_t         head;
  logic [TAG_W-1:0] head_tag, held_tag;
  logic [LW-1:0]    cnt;

  assign fifo_wdata         = {cmd_tag, cmd_op, cmd_a, cmd_b};
  assign {head_tag, head}   = fifo_rdata;
  assign cmd_ready          = !fifo_full;
  assign busy               = (state != IDLE);

  pes_alu_cmd_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == LW'(ALU_LAT)) begin
          cap       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (res_valid && res_ready) begin
          done = 1'b1;
          // Back-to-back issue: next command pops on the handoff edge.
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      held_tag  <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      op_count  <= '0;
    end else begin
      // ALU inputs change only on a pop and are held otherwise.
      if (pop) begin
        alu_a    <= head.a;
        alu_b    <= head.b;
        alu_op   <= head.op;
        held_tag <= head_tag;
        cnt      <= '0;
      end else if (state == EXEC) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        res_data  <= alu_r;
        res_tag   <= held_tag;
        res_valid <= 1'b1;
      end
      if (done) begin
        res_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pes_alu_sequencer.sv
module tb_pes_alu_sequencer;
  import pes_alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a, alu_b, alu_r;
  logic [2:0]       alu_op;
  logic             res_valid, res_ready;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       fifo_level;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  pes_alu_sequencer #(.TAG_W(TAG_W), .ALU_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .fifo_level(fifo_level), .busy(busy), .op_count(op_count)
  );

  function automatic logic [7:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_NOT:  return ~a;
      ALU_NAND: return ~(a & b);
      ALU_NOR:  return ~(a | b);
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      default:  return a ^ b;
    endcase
  endfunction

  // Registered ALU, one cycle latency.
  always_ff @(posedge clk) alu_r <= alu_ref(alu_op, alu_a, alu_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       exp_cur;
  logic [CNT_W-1:0] cnt_m;

  // Scoreboard: push on accepted command, pop/compare on result handoff.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      cnt_m = '0;
    end else begin
      if (cmd_valid && cmd_ready) sb.push_back('{exp_cur, cmd_tag});
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_res", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_data", 32'(res_data), 32'(e.data));
          chk("res_tag", 32'(res_tag), 32'(e.tag));
        end
        chk("op_count_hs", 32'(op_count), 32'(cnt_m));
        cnt_m = cnt_m + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(logic [2:0] op, logic [7:0] a, logic [7:0] b,
                         logic [TAG_W-1:0] tg, logic [7:0] e);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tg; exp_cur = e;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send(logic [2:0] op, logic [7:0] a, logic [7:0] b,
                      logic [TAG_W-1:0] tg, logic [7:0] e);
    logic acc;
    set_cmd(op, a, b, tg, e);
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
      if (acc) break;
      if (i == 199) chk("send_timeout", 1, 0);
    end
    cmd_valid = 1'b0;
  endtask

  // Offer commands 0..n-1 back-to-back for 'cycles' cycles, holding each until accepted.
  task automatic offer(int n, int cycles, output int accepted);
    int idx = 0;
    accepted = 0;
    for (int c = 0; c < cycles && idx < n; c++) begin
      set_cmd(ALU_ADD, 8'(idx * 7), 8'(idx + 16), TAG_W'(idx), alu_ref(ALU_ADD, 8'(idx * 7), 8'(idx + 16)));
      cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) begin
        accepted++;
        idx++;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sb.size() == 0 && !busy && fifo_level == 0 && !res_valid) break;
      if (i == 299) chk("drain_timeout", 1, 0);
    end
  endtask

  logic [7:0] op_exp [8];
  int         acc;
  logic [7:0] s_data, s_a, s_b;
  logic [2:0] s_op;
  logic [TAG_W-1:0] s_tag;
  logic       stale;

  initial begin
    op_exp = '{8'hE1, 8'h69, 8'h5A, 8'hDB, 8'h42, 8'h24, 8'hBD, 8'h99};
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    set_cmd(3'd0, 8'd0, 8'd0, '0, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_res_data", 32'(res_data), 0);

    // 1: single add with latency check
    res_ready = 1'b1;
    send(ALU_ADD, 8'h3C, 8'h05, 4'd1, 8'h41);
    tick(); chk("t1_valid_p1", 32'(res_valid), 0);
    tick(); chk("t1_valid_p2", 32'(res_valid), 0);
    tick(); chk("t1_valid_p3", 32'(res_valid), 1);
    chk("t1_data", 32'(res_data), 32'h41);
    chk("t1_tag", 32'(res_tag), 1);
    tick(); chk("t1_op_count", 32'(op_count), 1);
    chk("t1_valid_after", 32'(res_valid), 0);
    drain();

    // 2: all ops, back-to-back
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h3C, TAG_W'(i), op_exp[i]);
    drain();
    chk("t2_op_count", 32'(op_count), 9);

    // 3: wrap
    send(ALU_ADD, 8'hFF, 8'h02, 4'd9, 8'h01);
    send(ALU_SUB, 8'h00, 8'h01, 4'd10, 8'hFF);
    drain();

    // 4: fill with backpressure
    res_ready = 1'b0;
    offer(7, 7, acc);
    chk("t4_accepted", 32'(acc), 5);
    chk("t4_cmd_ready", 32'(cmd_ready), 0);
    chk("t4_level", 32'(fifo_level), 4);
    chk("t4_in_resp", 32'(res_valid), 1);

    // 5: hold in RESP for 10 cycles
    s_data = res_data; s_tag = res_tag; s_a = alu_a; s_b = alu_b; s_op = alu_op;
    chk("t5_head_data", 32'(s_data), 32'(alu_ref(ALU_ADD, 8'd0, 8'd16)));
    chk("t5_head_tag", 32'(s_tag), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_valid", 32'(res_valid), 1);
      chk("t5_stable", {res_data, res_tag, alu_a, alu_op, 1'b0},
                       {s_data, s_tag, s_a, s_op, 1'b0});
      chk("t5_alu_b", 32'(alu_b), 32'(s_b));
      chk("t5_level", 32'(fifo_level), 4);
    end
    res_ready = 1'b1;
    drain();
    chk("t4_cmd_ready_after", 32'(cmd_ready), 1);
    chk("t4_op_count", 32'(op_count), 16);

    // 6: reset during EXEC with 3 queued
    res_ready = 1'b0;
    offer(5, 8, acc);
    chk("t6_accepted", 32'(acc), 5);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    chk("t6_resp", 32'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t6_busy_exec", 32'(busy), 1);
    chk("t6_level_3", 32'(fifo_level), 3);
    chk("t6_exec_no_valid", 32'(res_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    chk("t6_op_count", 32'(op_count), 0);
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid || busy) stale = 1'b1;
    end
    chk("t6_no_stale", 32'(stale), 0);
    send(ALU_XOR, 8'hF0, 8'h0F, 4'd3, 8'hFF);
    drain();
    chk("t6_op_count_after", 32'(op_count), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
